bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Sequencer and round-robin arbiter for the CPU's multiplexed tagged memory bus. It accepts single-word read and write requests from NREQ requesters, such as the CPU core and a loader/DMA port. It drives the address strobe, read and write phases on the shared o_ad/o_tag bus, and returns load data and tag to the granted requester. It sits between the requesters and the 1 Mword tagged RAM.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 20, word-address width
- RD_WAIT, 0, extra cycles o_rd is held before load data is sampled (0..15)

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset
- m_req  in  NREQ  per-requester request
- m_we  in  NREQ  per-requester write enable (1 = store, 0 = load)
- m_addr  in  NREQ×AW  per-requester word address
- m_wdata  in  NREQ×64  per-requester store data
- m_wtag  in  NREQ×8  per-requester store tag
- m_ack  out  NREQ  one-cycle completion pulse, one-hot
- m_rdata  out  64  load data, valid while the matching m_ack is high
- m_rtag  out  8  load tag, valid while the matching m_ack is high
- i_data  in  64  memory load data
- i_tag  in  8  memory load tag
- o_ad  out  64  address/data bus
- o_tag  out  8  tag bus
- o_astb  out  1  address strobe
- o_rd  out  1  read phase
- o_wr  out  1  write phase

## Operation
- States:
  - IDLE: arbitrates.
  - ADDR: o_astb=1, o_ad = address zero-extended to 64.
  - WR: o_wr=1, o_ad = wdata, o_tag = wtag, ack.
  - RD: o_rd=1, held 1+RD_WAIT cycles by a down-counter.
  - CAP: o_rd=0; m_rdata=i_data, m_rtag=i_tag; ack.
- Transitions:
  - IDLE→ADDR when any m_req is high.
  - ADDR→WR if the latched we is 1, else ADDR→RD.
  - WR→IDLE.
  - RD→CAP when the counter reaches 0.
  - CAP→IDLE.
- Grant and latching:
  - At the IDLE→ADDR edge the winner's index, we, addr, wdata and wtag are latched.
  - Requester inputs are ignored after that edge; dropping m_req after the grant does not abort the transaction.
- Requester handshake:
  - A requester holds m_req high until it sees its m_ack.
  - It may reassert or keep m_req high in the ack cycle for a new request.
- Round-robin:
  - The search starts at last_grant+1 modulo NREQ.
  - last_grant updates on each grant.
  - After reset last_grant = NREQ-1, so requester 0 wins the first tie.
- Bus outputs outside their phases:
  - o_ad = 0, o_tag = 0, strobes = 0.
  - Exactly one of o_astb/o_rd/o_wr is high in any cycle, or none.
- m_rdata/m_rtag are 0 when no read ack is active. m_ack is never asserted in IDLE.
- Only one transaction is in flight; there is no pipelining.

## Timing
- Reset (asynchronous, active-low):
  - state = IDLE, counter = 0, last_grant = NREQ-1, latched registers = 0.
  - All outputs 0, including m_ack, o_ad, o_tag and the strobes.
  - Reset asserted mid-transaction aborts it with no ack; no strobe remains high after reset.
- Write: request sampled at edge E; ADDR in cycle E..E+1; WR with m_ack in E+1..E+2; IDLE at E+2. Write occupancy is 3 cycles, including IDLE.
- Read: ADDR at E, RD for 1+RD_WAIT cycles, then CAP with m_ack. Ack cycle is E+2+RD_WAIT; read occupancy is 4+RD_WAIT cycles.
- Back-to-back: a request held through its own ack is re-arbitrated in the following IDLE cycle. The minimum gap between transactions is one IDLE cycle.
- Simultaneous requests: the round-robin winner proceeds and the losers wait. With both requesters continuously requesting, grants alternate strictly.
- All outputs are decoded from registered state and latched fields only, with no combinational path from m_req to the bus. Exception: m_rdata/m_rtag pass i_data/i_tag through in CAP.

## Structure
- Package bus_pkg:
  - state enum (IDLE, ADDR, WR, RD, CAP)
  - AD_W = 64, TAG_W = 8, default AW
  - function zext_addr
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req vector and last_grant. Outputs: any and a grant index.
  - Instantiated once.
- Top module: FSM, RD_WAIT counter, latch registers, output decode. Target size about 200 lines.

## Test plan
- Single write: requester 0 writes addr 0x00012, data 0x0123456789ABCDEF, tag 0x5A.
  - Required bus sequence: o_astb with o_ad=0x12, then o_wr with that data and tag.
  - m_ack[0] pulses in the WR cycle; the RAM model holds the data and tag.
- Read-back with RD_WAIT=0 and RD_WAIT=3: read addr 0x00012.
  - m_ack[0] is at E+2 and E+5 respectively.
  - m_rdata = 0x0123456789ABCDEF and m_rtag = 0x5A in the ack cycle.
- Contention: both requesters hold m_req for 6 transactions.
  - Grant order is 0,1,0,1,0,1.
  - The gap between consecutive acks is exactly the transaction length plus 1.
- Request withdrawal: requester 1 drops m_req and changes m_addr one cycle after the grant.
  - The bus still uses the latched address, and m_ack[1] still pulses.
- Reset mid-read: assert reset during RD.
  - Next cycle all outputs are 0 and no ack is issued.
  - After release, requester 0 wins a tie against requester 1.
- Idle bus: no requests for 20 cycles. o_astb, o_rd, o_wr, o_ad and m_ack stay 0 throughout.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the tagged memory bus sequencer.
package bus_pkg;

  localparam int unsigned AD_W   = 64;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned AW_DEF = 20;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWr,
    StRd,
    StCap
  } state_e;

  // Keeps only the low aw bits of a word address widened onto the AD bus.
  function automatic logic [AD_W-1:0] zext_addr(input logic [AD_W-1:0] addr,
                                                input int unsigned    aw);
    logic [AD_W-1:0] mask;
    mask = (aw >= AD_W) ? '1 : ((AD_W'(1) << aw) - AD_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the previous winner.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last_grant,
  output logic            o_any,
  output logic [IW-1:0]   o_grant
);

  logic [IW-1:0] w_idx;

  // Walk the ring backwards so the nearest requester after last_grant is written last.
  always_comb begin
    o_any   = |i_req;
    o_grant = '0;
    w_idx   = '0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      w_idx = IW'((32'(i_last_grant) + i) % NREQ);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Sequencer and round-robin arbiter driving the multiplexed tagged memory bus.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned RD_WAIT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            m_req,
  input  logic [NREQ-1:0]            m_we,
  input  logic [NREQ-1:0][AW-1:0]    m_addr,
  input  logic [NREQ-1:0][AD_W-1:0]  m_wdata,
  input  logic [NREQ-1:0][TAG_W-1:0] m_wtag,
  output logic [NREQ-1:0]            m_ack,
  output logic [AD_W-1:0]            m_rdata,
  output logic [TAG_W-1:0]           m_rtag,
  input  logic [AD_W-1:0]            i_data,
  input  logic [TAG_W-1:0]           i_tag,
  output logic [AD_W-1:0]            o_ad,
  output logic [TAG_W-1:0]           o_tag,
  output logic                       o_astb,
  output logic                       o_rd,
  output logic                       o_wr
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = 4;

  state_e           r_state;
  state_e           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_idx;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [AD_W-1:0]  r_wdata;
  logic [TAG_W-1:0] r_wtag;

  logic             w_any;
  logic [IW-1:0]    w_grant;
  logic             w_fire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req        (m_req),
    .i_last_grant (r_last),
    .o_any        (w_any),
    .o_grant      (w_grant)
  );

  assign w_fire = (r_state == StIdle) && w_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_any) w_state_next = StAddr;
      StAddr:  w_state_next = r_we ? StWr : StRd;
      StWr:    w_state_next = StIdle;
      StRd:    if (r_cnt == '0) w_state_next = StCap;
      StCap:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Requester inputs are captured once, at the grant edge, and ignored afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_last  <= IW'(NREQ - 1);
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wtag  <= '0;
    end else if (w_fire) begin
      r_idx   <= w_grant;
      r_last  <= w_grant;
      r_we    <= m_we[w_grant];
      r_addr  <= m_addr[w_grant];
      r_wdata <= m_wdata[w_grant];
      r_wtag  <= m_wtag[w_grant];
    end
  end

  // Loaded on the way into RD so the read phase lasts 1+RD_WAIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if ((r_state == StAddr) && !r_we) begin
      r_cnt <= CW'(RD_WAIT);
    end else if ((r_state == StRd) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    o_ad    = '0;
    o_tag   = '0;
    o_astb  = 1'b0;
    o_rd    = 1'b0;
    o_wr    = 1'b0;
    m_ack   = '0;
    m_rdata = '0;
    m_rtag  = '0;
    unique case (r_state)
      StAddr: begin
        o_astb = 1'b1;
        o_ad   = zext_addr(AD_W'(r_addr), AW);
      end
      StWr: begin
        o_wr         = 1'b1;
        o_ad         = r_wdata;
        o_tag        = r_wtag;
        m_ack[r_idx] = 1'b1;
      end
      StRd: begin
        o_rd = 1'b1;
      end
      StCap: begin
        m_ack[r_idx] = 1'b1;
        m_rdata      = i_data;
        m_rtag       = i_tag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small RAM model behind each instance.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       m_req, m_req3, m_we;
  logic [1:0][19:0] m_addr;
  logic [1:0][63:0] m_wdata;
  logic [1:0][7:0]  m_wtag;

  logic [1:0]  ack0, ack3;
  logic [63:0] rdata0, rdata3, ad0, ad3, i_data0, i_data3;
  logic [7:0]  rtag0, rtag3, tag0, tag3, i_tag0, i_tag3;
  logic        astb0, rd0, wr0, astb3, rd3, wr3;

  logic [71:0] mem0 [256];
  logic [71:0] mem3 [256];
  logic [19:0] ra0, ra3;

  int checks = 0;
  int errors = 0;
  int n;

  bus_arbiter #(.NREQ(2), .AW(20), .RD_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wtag(m_wtag), .m_ack(ack0), .m_rdata(rdata0), .m_rtag(rtag0),
    .i_data(i_data0), .i_tag(i_tag0), .o_ad(ad0), .o_tag(tag0), .o_astb(astb0),
    .o_rd(rd0), .o_wr(wr0)
  );

  bus_arbiter #(.NREQ(2), .AW(20), .RD_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .m_req(m_req3), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wtag(m_wtag), .m_ack(ack3), .m_rdata(rdata3), .m_rtag(rtag3),
    .i_data(i_data3), .i_tag(i_tag3), .o_ad(ad3), .o_tag(tag3), .o_astb(astb3),
    .o_rd(rd3), .o_wr(wr3)
  );

  always @(posedge clk) begin
    if (astb0) ra0 <= ad0[19:0];
    if (wr0) mem0[ra0[7:0]] <= {tag0, ad0};
    if (astb3) ra3 <= ad3[19:0];
    if (wr3) mem3[ra3[7:0]] <= {tag3, ad3};
  end
  assign i_data0 = mem0[ra0[7:0]][63:0];
  assign i_tag0  = mem0[ra0[7:0]][71:64];
  assign i_data3 = mem3[ra3[7:0]][63:0];
  assign i_tag3  = mem3[ra3[7:0]][71:64];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    chk("excl0", 72'($onehot0({astb0, rd0, wr0})), 72'd1);
    chk("excl3", 72'($onehot0({astb3, rd3, wr3})), 72'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem3[i] = '0;
    end
    ra0 = '0; ra3 = '0;
    m_req = '0; m_req3 = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_wtag = '0;
    step(); step();
    chk("rst_strobes", {astb0, rd0, wr0, ack0}, 0);
    chk("rst_ad", {tag0, ad0}, 0);
    chk("rst_rdata", {rtag0, rdata0}, 0);
    reset = 1'b1;
    step();

    // Single write by requester 0
    m_req = 2'b01; m_we = 2'b01; m_addr[0] = 20'h00012;
    m_wdata[0] = 64'h0123456789ABCDEF; m_wtag[0] = 8'h5A;
    step();
    chk("wr_addr", {astb0, ack0, ad0}, {1'b1, 2'b00, 64'h12});
    step();
    chk("wr_data", {wr0, ad0}, {1'b1, 64'h0123456789ABCDEF});
    chk("wr_tag_ack", {tag0, ack0}, {8'h5A, 2'b01});
    m_req = 2'b00;
    step();
    chk("wr_idle", {astb0, rd0, wr0, ack0}, 0);
    chk("wr_mem", mem0[8'h12], {8'h5A, 64'h0123456789ABCDEF});

    // Read-back, RD_WAIT = 0
    m_req = 2'b01; m_we = 2'b00;
    step();
    chk("rd_addr", {astb0, ad0}, {1'b1, 64'h12});
    step();
    chk("rd_phase", {rd0, ack0}, {1'b1, 2'b00});
    step();
    chk("rd_ack", {rd0, ack0}, {1'b0, 2'b01});
    chk("rd_data", {rtag0, rdata0}, {8'h5A, 64'h0123456789ABCDEF});
    m_req = 2'b00;
    step();
    chk("rd_rdata_clr", {ack0, rtag0, rdata0}, 0);

    // RD_WAIT = 3 instance: write then read, ack expected at E+5
    m_req3 = 2'b01; m_we = 2'b01;
    step(); step();
    chk("w3_ack", ack3, 2'b01);
    m_req3 = 2'b00;
    step();
    m_req3 = 2'b01; m_we = 2'b00;
    n = 0;
    do begin step(); n++; end while (ack3 == 2'b00 && n < 20);
    chk("r3_latency", n, 6);
    chk("r3_data", {rtag3, rdata3}, {8'h5A, 64'h0123456789ABCDEF});
    m_req3 = 2'b00;
    step();

    // Requester 1 withdraws and changes its inputs right after the grant
    m_req = 2'b10; m_we = 2'b10; m_addr[1] = 20'h00034;
    m_wdata[1] = 64'hCAFEF00DDEADBEEF; m_wtag[1] = 8'hC3;
    step();
    m_req = 2'b00; m_addr[1] = 20'h00077; m_wdata[1] = 64'h1111; m_wtag[1] = 8'h00;
    #1;
    chk("wd_addr", {astb0, ad0}, {1'b1, 64'h34});
    step();
    chk("wd_data", {ack0, tag0, ad0}, {2'b10, 8'hC3, 64'hCAFEF00DDEADBEEF});
    step();
    chk("wd_mem", mem0[8'h34], {8'hC3, 64'hCAFEF00DDEADBEEF});

    // Contention: both write continuously, grants alternate starting with 0
    m_we = 2'b11; m_addr[0] = 20'h00040; m_addr[1] = 20'h00041;
    m_wdata[0] = 64'hA0A0; m_wtag[0] = 8'h10; m_wdata[1] = 64'hB1B1; m_wtag[1] = 8'h11;
    m_req = 2'b11;
    for (int t = 0; t < 6; t++) begin
      n = 0;
      do begin step(); n++; end while (ack0 == 2'b00 && n < 20);
      chk("cont_order", ack0, (t % 2 == 0) ? 2'b01 : 2'b10);
      if (t > 0) chk("cont_gap", n, 3);
    end
    m_req = 2'b00;
    step();
    chk("cont_mem", {mem0[8'h40], mem0[8'h41][7:0]}, {8'h10, 64'hA0A0, 8'hB1});

    // Reset in the middle of a read
    m_req = 2'b01; m_we = 2'b00; m_addr[0] = 20'h00012;
    step(); step();
    chk("mr_rd", rd0, 1'b1);
    reset = 1'b0;
    #1;
    chk("mr_strobes", {astb0, rd0, wr0, ack0}, 0);
    chk("mr_bus", {tag0, ad0}, 0);
    step();
    chk("mr_noack", {ack0, rdata0}, 0);
    m_we = 2'b11; m_addr[0] = 20'h00050; m_addr[1] = 20'h00051; m_req = 2'b11;
    reset = 1'b1;
    step();
    chk("mr_tie", {astb0, ad0}, {1'b1, 64'h50});
    step();
    chk("mr_ack", ack0, 2'b01);
    m_req = 2'b00;
    step();

    // Idle bus
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle", {astb0, rd0, wr0, ack0, ad0}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
